// File: rtl/vram_row_arbiter.sv
// vram_row_arbiter: shares one VRAM port between CPU accesses and per-text-row prefetches
// into a pair of 20-word line buffers (active/back) that swap at the end of a raster line.
// Optional: define VRAM_ARB_STALL_STATS_EN to count CPU cycles stalled behind a prefetch.
`timescale 1ns/1ps
module vram_row_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_draw_x,
  input  logic [9:0]  i_draw_y,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [3:0]  i_cpu_be,
  input  logic [9:0]  i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_ack,
  output logic [31:0] o_cpu_rdata,
  output logic [9:0]  o_vram_addr,
  output logic        o_vram_we,
  output logic [3:0]  o_vram_be,
  output logic [31:0] o_vram_wdata,
  input  logic [31:0] i_vram_rdata,
  output logic [31:0] o_char_word,
  output logic        o_fetch_busy,
  output logic [15:0] o_cpu_stall_cnt
);

  typedef enum logic [1:0] {IDLE, CPU_RD, FETCH, DRAIN} state_t;

  state_t      r_state, w_state_next;
  logic        r_sel;          // which buffer is active for display
  logic        r_swap_pend;    // a completed fetch waits for end of line
  logic        r_wr_ack;       // write ack, one cycle after issue
  logic        r_ack_q;        // ack seen last cycle: ignore cpu_req once more
  logic [4:0]  r_row;
  logic [4:0]  r_word;
  logic [31:0] r_buf [2][20];

  logic        w_trigger;
  logic [4:0]  w_trig_row;
  logic        w_cpu_serve;
  logic        w_back;
  logic [9:0]  w_fetch_base;

  // Last scanline of a text row (or of the frame) kicks off the next row's fetch
  assign w_trigger = (i_draw_x == 10'd640) &&
                     (((i_draw_y[3:0] == 4'hF) && (i_draw_y < 10'd479)) ||
                      (i_draw_y == 10'd524));
  // drawY < 479 on the row path, so bit 9 is always clear there
  assign w_trig_row   = (i_draw_y == 10'd524) ? 5'd0 : (i_draw_y[8:4] + 5'd1);
  assign w_back       = ~r_sel;
  assign w_fetch_base = {5'd0, r_row} * 10'd20;

  assign o_cpu_ack    = r_wr_ack | (r_state == CPU_RD);
  assign o_cpu_rdata  = (r_state == CPU_RD) ? i_vram_rdata : 32'd0;
  assign o_fetch_busy = (r_state == FETCH) || (r_state == DRAIN);
  assign w_cpu_serve  = i_cpu_req && !o_cpu_ack && !r_ack_q && !i_rst;
  assign o_char_word  = (i_draw_x < 10'd640) ? r_buf[r_sel][i_draw_x[9:5]] : 32'd0;

  // Next-state and VRAM port drive; the prefetch trigger always beats a CPU request
  always_comb begin
    w_state_next = r_state;
    o_vram_addr  = 10'd0;
    o_vram_we    = 1'b0;
    o_vram_be    = 4'd0;
    o_vram_wdata = 32'd0;
    unique case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_next = FETCH;
        end else if (w_cpu_serve) begin
          o_vram_addr = i_cpu_addr;
          if (i_cpu_we) begin
            o_vram_we    = 1'b1;
            o_vram_be    = i_cpu_be;
            o_vram_wdata = i_cpu_wdata;
          end else begin
            o_vram_be    = 4'hF;
            w_state_next = CPU_RD;
          end
        end
      end
      CPU_RD: w_state_next = w_trigger ? FETCH : IDLE;
      FETCH: begin
        o_vram_addr = w_fetch_base + {5'd0, r_word};
        o_vram_be   = 4'hF;
        if (r_word == 5'd19) w_state_next = DRAIN;
      end
      DRAIN: w_state_next = IDLE;
    endcase
  end

  // State, handshake flags, fetch bookkeeping and line buffers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sel       <= 1'b0;
      r_swap_pend <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_ack_q     <= 1'b0;
      r_row       <= 5'd0;
      r_word      <= 5'd0;
      for (int i = 0; i < 20; i++) begin
        r_buf[0][i] <= 32'd0;
        r_buf[1][i] <= 32'd0;
      end
    end else begin
      r_state  <= w_state_next;
      r_ack_q  <= o_cpu_ack;
      r_wr_ack <= (r_state == IDLE) && !w_trigger && w_cpu_serve && i_cpu_we;
      if (w_trigger && ((r_state == IDLE) || (r_state == CPU_RD))) r_row <= w_trig_row;
      r_word <= (r_state == FETCH) ? r_word + 5'd1 : 5'd0;
      // Read data lags its address by one cycle
      if ((r_state == FETCH) && (r_word != 5'd0)) begin
        r_buf[w_back][r_word - 5'd1] <= i_vram_rdata;
      end else if (r_state == DRAIN) begin
        r_buf[w_back][19] <= i_vram_rdata;
      end
      if (r_state == DRAIN) begin
        r_swap_pend <= 1'b1;
      end else if ((i_draw_x == 10'd799) && r_swap_pend) begin
        r_sel       <= ~r_sel;
        r_swap_pend <= 1'b0;
      end
    end
  end

`ifdef VRAM_ARB_STALL_STATS_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles the CPU waits behind a prefetch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= 16'd0;
    end else if (i_cpu_req && o_fetch_busy && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_cpu_stall_cnt = r_stall_cnt;
`else
  assign o_cpu_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vram_row_arbiter.sv
// Directed bench for vram_row_arbiter with a behavioural one-cycle-latency VRAM.
`timescale 1ns/1ps
module tb_vram_row_arbiter;

  logic        clk;
  logic        rst;
  logic [9:0]  draw_x, draw_y;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_be;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [9:0]  vram_addr;
  logic        vram_we;
  logic [3:0]  vram_be;
  logic [31:0] vram_wdata;
  logic [31:0] vram_rdata;
  logic [31:0] char_word;
  logic        fetch_busy;
  logic [15:0] cpu_stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  vram_row_arbiter dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_draw_x        (draw_x),
    .i_draw_y        (draw_y),
    .i_cpu_req       (cpu_req),
    .i_cpu_we        (cpu_we),
    .i_cpu_be        (cpu_be),
    .i_cpu_addr      (cpu_addr),
    .i_cpu_wdata     (cpu_wdata),
    .o_cpu_ack       (cpu_ack),
    .o_cpu_rdata     (cpu_rdata),
    .o_vram_addr     (vram_addr),
    .o_vram_we       (vram_we),
    .o_vram_be       (vram_be),
    .o_vram_wdata    (vram_wdata),
    .i_vram_rdata    (vram_rdata),
    .o_char_word     (char_word),
    .o_fetch_busy    (fetch_busy),
    .o_cpu_stall_cnt (cpu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back a fixed pattern: word at address a = 0x41424344 + a
  logic [31:0] mem   [1024];
  bit          valid [1024];

  function automatic logic [31:0] pat(input logic [9:0] a);
    return 32'h41424344 + {22'd0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (vram_we) begin
      mem[vram_addr]   <= merge(valid[vram_addr] ? mem[vram_addr] : pat(vram_addr),
                                vram_wdata, vram_be);
      valid[vram_addr] <= 1'b1;
    end
    vram_rdata <= valid[vram_addr] ? mem[vram_addr] : pat(vram_addr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Step drawX from x0 to x1 on line y; check fetch addresses and busy length
  task automatic sweep(input logic [9:0] y, input int x0, input int x1, input int row);
    int busy;
    busy   = 0;
    draw_y = y;
    for (int x = x0; x <= x1; x++) begin
      draw_x = 10'(x);
      #1;
      if (fetch_busy) begin
        if (busy < 20) check("fetch_addr", {22'd0, vram_addr}, 32'(row * 20 + busy));
        busy++;
      end
      cyc();
    end
    check("fetch_busy_cycles", 32'(busy), 32'd21);
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_be = be;
    #1;
    check("wr_issue_we", {31'd0, vram_we}, 32'd1);
    check("wr_issue_addr", {22'd0, vram_addr}, {22'd0, a});
    check("wr_issue_data", vram_wdata, d);
    check("wr_issue_ack", {31'd0, cpu_ack}, 32'd0);
    cyc();
    check("wr_ack", {31'd0, cpu_ack}, 32'd1);
    check("wr_ack_cycle_we", {31'd0, vram_we}, 32'd0);
    cyc();
    check("wr_post_ack_ignored", {31'd0, vram_we}, 32'd0);
    check("wr_post_ack_noack", {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b0;
    cyc();
  endtask

  task automatic cpu_read(input logic [9:0] a, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    check("rd_issue_addr", {22'd0, vram_addr}, {22'd0, a});
    check("rd_issue_we", {31'd0, vram_we}, 32'd0);
    check("rd_issue_be", {28'd0, vram_be}, 32'hF);
    check("rd_issue_ack", {31'd0, cpu_ack}, 32'd0);
    cyc();
    check("rd_ack", {31'd0, cpu_ack}, 32'd1);
    check("rd_data", cpu_rdata, exp);
    cyc();
    check("rd_post_ack_noack", {31'd0, cpu_ack}, 32'd0);
    check("rd_post_ack_ignored", {22'd0, vram_addr}, 32'd0);
    cpu_req = 1'b0;
    cyc();
  endtask

  task automatic peek_char(input string tag, input int x, input logic [31:0] exp);
    draw_x = 10'(x);
    #1;
    check(tag, char_word, exp);
  endtask

  initial begin
    int lat;
    logic got;
    rst = 1'b1; draw_x = 10'd0; draw_y = 10'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 10'd3; cpu_wdata = 32'h12345678;
    #12;
    // Reset state, including a CPU write request held during reset
    check("rst_vram_we", {31'd0, vram_we}, 32'd0);
    check("rst_vram_addr", {22'd0, vram_addr}, 32'd0);
    check("rst_vram_be", {28'd0, vram_be}, 32'd0);
    check("rst_vram_wdata", vram_wdata, 32'd0);
    check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_fetch_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_stall_cnt", {16'd0, cpu_stall_cnt}, 32'd0);
    check("rst_char_word", char_word, 32'd0);
    cpu_req = 1'b0;
    cyc();
    rst = 1'b0;
    draw_x = 10'd100; draw_y = 10'd100;
    cyc();

    // CPU write then readback, plus a byte-masked write
    cpu_write(10'd5, 32'hDEADBEEF, 4'hF);
    cpu_read(10'd5, 32'hDEADBEEF);
    cpu_write(10'd600, 32'h11223344, 4'b0011);
    cpu_read(10'd600, 32'h41423344);

    // Frame-end prefetch of row 0; swap only at drawX == 799
    sweep(10'd524, 640, 700, 0);
    peek_char("pre_swap_row0", 32, 32'd0);
    draw_x = 10'd799; cyc();
    draw_y = 10'd0;
    peek_char("row0_word1", 32, 32'h41424345);
    peek_char("row0_x639", 639, 32'h41424357);
    peek_char("row0_x640", 640, 32'd0);
    cyc();

    // Line 15 prefetches row 1 (addresses 20..39)
    sweep(10'd15, 640, 700, 1);
    peek_char("pre_swap_row1", 0, 32'h41424344);
    draw_x = 10'd799; cyc();
    draw_y = 10'd16;
    peek_char("row1_word0", 0, 32'h41424358);
    cyc();

    // CPU read raised together with the row-2 trigger waits behind the fetch
    draw_y = 10'd31; draw_x = 10'd640;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    #1;
    check("trig_cycle_no_cpu_addr", {22'd0, vram_addr}, 32'd0);
    check("trig_cycle_no_ack", {31'd0, cpu_ack}, 32'd0);
    cyc();
    lat = 0; got = 1'b0;
    for (int t = 1; t <= 40 && !got; t++) begin
      draw_x = 10'(640 + t);
      #1;
      if (cpu_ack) begin
        got = 1'b1;
        lat = t;
        check("stalled_rd_data", cpu_rdata, 32'hDEADBEEF);
      end
      cyc();
    end
    cpu_req = 1'b0;
    check("stalled_ack_seen", {31'd0, got}, 32'd1);
    // trigger cycle 0, FETCH 1..20, DRAIN 21, read issue 22, ack 23
    check("stalled_ack_latency", 32'(lat), 32'd23);
`ifdef VRAM_ARB_STALL_STATS_EN
    check("stall_cnt", {16'd0, cpu_stall_cnt}, 32'd21);
`else
    check("stall_cnt", {16'd0, cpu_stall_cnt}, 32'd0);
`endif
    cyc();

    // Reset mid-fetch at word 10 of row 3, then a clean refetch
    draw_y = 10'd47; draw_x = 10'd640; #1; cyc();
    for (int k = 0; k < 10; k++) begin
      draw_x = 10'(641 + k);
      cyc();
    end
    draw_x = 10'd651;
    #1;
    check("abort_word10_addr", {22'd0, vram_addr}, 32'd70);
    check("abort_busy_before", {31'd0, fetch_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy_after", {31'd0, fetch_busy}, 32'd0);
    check("abort_addr_after", {22'd0, vram_addr}, 32'd0);
    cyc();
    rst = 1'b0;
    draw_x = 10'd799; cyc();
    peek_char("abort_no_swap", 0, 32'd0);
    cyc();
    sweep(10'd47, 640, 700, 3);
    peek_char("refetch_pre_swap", 0, 32'd0);
    draw_x = 10'd799; cyc();
    draw_y = 10'd48;
    peek_char("row3_word0", 0, 32'h41424380);
    peek_char("row3_x639", 639, 32'h41424393);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
